mem_tile_rsp: RTL and testbench

// Responder (memory) end of the L1 fetch tile bus (memPcAddr/memPcOpm ->

---
 rtl/mem_tile_rsp.sv | 111 +++++++++++
 tb/tb_mem_tile_rsp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_tile_rsp.sv
// Memory responder for the L1 fetch tile bus: serves 128-bit tiles from a local array
// with a fixed HOLD latency, range checking and a backdoor preload port.
module mem_tile_rsp #(
  parameter int unsigned TILE_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          memPcAddr,
  input  logic [4:0]           memPcOpm,
  output logic [127:0]         memPcData,
  output logic [1:0]           memPcOK,
  input  logic                 bdWrEn,
  input  logic [TILE_LOG2-1:0] bdWrIx,
  input  logic [127:0]         bdWrData,
  output logic [15:0]          reqCount
);

  localparam logic [4:0] OpmReady  = 5'h00;
  localparam logic [4:0] OpmRdTile = 5'h0F;
  localparam logic [1:0] OkReady   = 2'b00;
  localparam logic [1:0] OkOk      = 2'b01;
  localparam logic [1:0] OkHold    = 2'b10;
  localparam logic [1:0] OkFault   = 2'b11;
  localparam logic [3:0] LatInit   = 4'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StFlt} state_e;

  state_e               state;
  logic [3:0]           lat_cnt;
  logic [TILE_LOG2-1:0] ix_q;
  logic                 rng_q;
  logic [127:0]         mem [2**TILE_LOG2];

  logic [31:0] off;
  logic        in_rng;

  assign off    = memPcAddr - BASE_ADDR;
  // Below-base addresses wrap to a huge offset, so the >= check rejects them explicitly.
  assign in_rng = (memPcAddr >= BASE_ADDR) && ((off >> (TILE_LOG2 + 4)) == 32'd0);

  always_ff @(posedge clock) begin
    if (bdWrEn) mem[bdWrIx] <= bdWrData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      lat_cnt   <= '0;
      ix_q      <= '0;
      rng_q     <= 1'b0;
      memPcData <= '0;
      memPcOK   <= OkReady;
      reqCount  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (memPcOpm == OpmRdTile) begin
            ix_q    <= off[TILE_LOG2+3:4];
            rng_q   <= in_rng;
            lat_cnt <= LatInit;
            state   <= StBusy;
            memPcOK <= OkHold;
          end else if (memPcOpm != OpmReady) begin
            state   <= StFlt;
            memPcOK <= OkFault;
          end
        end
        StBusy: begin
          if (memPcOpm == OpmReady) begin
            state   <= StIdle;
            memPcOK <= OkReady;
          end else if (lat_cnt == 4'd1) begin
            // Array write on this same edge is not visible here: old data returned.
            if (rng_q) begin
              memPcData <= mem[ix_q];
              state     <= StDone;
              memPcOK   <= OkOk;
            end else begin
              state     <= StFlt;
              memPcOK   <= OkFault;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        StDone: begin
          if (memPcOpm == OpmReady) begin
            memPcData <= '0;
            reqCount  <= reqCount + 16'd1;
            state     <= StIdle;
            memPcOK   <= OkReady;
          end
        end
        StFlt: begin
          if (memPcOpm == OpmReady) begin
            reqCount <= reqCount + 16'd1;
            state    <= StIdle;
            memPcOK  <= OkReady;
          end
        end
        default: begin
          state   <= StIdle;
          memPcOK <= OkReady;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tile_rsp.sv
// Self-checking bench for mem_tile_rsp: directed protocol cases plus random reads
// checked against an array/arithmetic reference model.
module tb_mem_tile_rsp;

  localparam int unsigned TL   = 10;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned LAT  = 3;
  localparam int unsigned NT   = 1 << TL;

  localparam logic [4:0] OPM_READY = 5'h00;
  localparam logic [4:0] OPM_RD    = 5'h0F;
  localparam logic [1:0] OK_READY  = 2'b00;
  localparam logic [1:0] OK_OK     = 2'b01;
  localparam logic [1:0] OK_HOLD   = 2'b10;
  localparam logic [1:0] OK_FAULT  = 2'b11;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   memPcAddr;
  logic [4:0]    memPcOpm;
  logic [127:0]  memPcData;
  logic [1:0]    memPcOK;
  logic          bdWrEn;
  logic [TL-1:0] bdWrIx;
  logic [127:0]  bdWrData;
  logic [15:0]   reqCount;

  int total = 0;
  int bad   = 0;
  logic [127:0] ref_mem [NT];
  logic [15:0]  exp_cnt;

  mem_tile_rsp #(.TILE_LOG2(TL), .BASE_ADDR(BASE), .RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .memPcAddr(memPcAddr), .memPcOpm(memPcOpm),
    .memPcData(memPcData), .memPcOK(memPcOK), .bdWrEn(bdWrEn), .bdWrIx(bdWrIx),
    .bdWrData(bdWrData), .reqCount(reqCount)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Full RD_TILE transaction, starting just after a negedge.
  task automatic do_read(input logic [31:0] addr, input bit wr_at_done,
                         input logic [127:0] wdata, input bit chg_addr);
    longint a = longint'(addr);
    bit rng = (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(NT) * 16);
    int ix = rng ? int'((a - longint'(BASE)) / 16) : 0;
    logic [127:0] exp_data = rng ? ref_mem[ix] : '0;
    memPcOpm  = OPM_RD;
    memPcAddr = addr;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(negedge clock);
      chk("hold", 128'(memPcOK), 128'(OK_HOLD));
      if (i == 1 && chg_addr) memPcAddr = addr + 32'h10;
      if (i == int'(LAT) && wr_at_done) begin
        bdWrEn = 1'b1; bdWrIx = TL'(ix); bdWrData = wdata;
      end
    end
    @(negedge clock);
    bdWrEn = 1'b0;
    chk("ok_code", 128'(memPcOK), rng ? 128'(OK_OK) : 128'(OK_FAULT));
    chk("data", memPcData, exp_data);
    if (wr_at_done) ref_mem[ix] = wdata;
    memPcOpm = OPM_READY;
    exp_cnt++;
    @(negedge clock);
    chk("ready_after", 128'(memPcOK), 128'(OK_READY));
    chk("data_cleared", memPcData, '0);
    chk("count", 128'(reqCount), 128'(exp_cnt));
  endtask

  initial begin
    logic [127:0] w;
    int last_tile, misses;
    logic [15:0] cnt0;
    reset = 1'b1; memPcAddr = '0; memPcOpm = OPM_READY;
    bdWrEn = 1'b0; bdWrIx = '0; bdWrData = '0; exp_cnt = '0;
    @(negedge clock);
    chk("rst_ok", 128'(memPcOK), 128'(OK_READY));
    chk("rst_data", memPcData, '0);
    chk("rst_count", 128'(reqCount), '0);
    reset = 1'b0;

    // Preload every tile through the backdoor.
    for (int i = 0; i < int'(NT); i++) begin
      w = (i == 5) ? 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF : rnd128();
      bdWrEn = 1'b1; bdWrIx = TL'(i); bdWrData = w; ref_mem[i] = w;
      @(negedge clock);
    end
    bdWrEn = 1'b0;
    @(negedge clock);

    do_read(BASE + 32'h50, 1'b0, '0, 1'b0);
    do_read(BASE + 32'h5C, 1'b0, '0, 1'b1);
    do_read(BASE + 32'h4000, 1'b0, '0, 1'b0);
    do_read(BASE - 32'h10, 1'b0, '0, 1'b0);
    do_read(BASE + 32'h3FF0, 1'b0, '0, 1'b0);
    do_read(BASE + 32'h50, 1'b1, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF, 1'b0);
    do_read(BASE + 32'h50, 1'b0, '0, 1'b0);

    // Abort after one HOLD cycle.
    memPcOpm = OPM_RD; memPcAddr = BASE + 32'h80;
    @(negedge clock);
    chk("abort_hold", 128'(memPcOK), 128'(OK_HOLD));
    memPcOpm = OPM_READY;
    @(negedge clock);
    chk("abort_ready", 128'(memPcOK), 128'(OK_READY));
    chk("abort_count", 128'(reqCount), 128'(exp_cnt));
    do_read(BASE + 32'h80, 1'b0, '0, 1'b0);

    // Unsupported opcode faults, then counts on return to READY.
    memPcOpm = 5'h1F;
    @(negedge clock);
    chk("badopm_fault", 128'(memPcOK), 128'(OK_FAULT));
    chk("badopm_data", memPcData, '0);
    memPcOpm = OPM_READY; exp_cnt++;
    @(negedge clock);
    chk("badopm_ready", 128'(memPcOK), 128'(OK_READY));
    chk("badopm_count", 128'(reqCount), 128'(exp_cnt));

    // Async reset while in DONE.
    memPcOpm = OPM_RD; memPcAddr = BASE + 32'h50;
    repeat (LAT) @(negedge clock);
    @(negedge clock);
    chk("pre_rst_ok", 128'(memPcOK), 128'(OK_OK));
    reset = 1'b1;
    #1;
    chk("arst_ok", 128'(memPcOK), 128'(OK_READY));
    chk("arst_data", memPcData, '0);
    chk("arst_count", 128'(reqCount), '0);
    exp_cnt = '0;
    memPcOpm = OPM_READY;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 128'(memPcOK), 128'(OK_READY));

    // Random reads, including out-of-range on both sides.
    for (int k = 0; k < 40; k++)
      do_read(BASE - 32'h100 + 32'($urandom_range(0, 32'h4200)), 1'b0, '0, 1'b0);

    // Fetch sweep through a one-line I$ model: one request per new tile.
    cnt0 = reqCount; last_tile = -1; misses = 0;
    for (int pc = 0; pc <= 'h3F0; pc += 4) begin
      if (pc / 16 != last_tile) begin
        do_read(BASE + 32'(pc), 1'b0, '0, 1'b0);
        misses++;
        last_tile = pc / 16;
      end
    end
    chk("sweep_count", 128'(reqCount), 128'(cnt0 + 16'(misses)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
